// File: rtl/uart_bus_bridge_pkg.sv
// Shared opcodes, response codes and FSM state encoding for the UART-to-bus bridge.
package uart_bus_bridge_pkg;

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;
    localparam logic [7:0] OP_PING     = 8'h03;

    localparam logic [7:0] RSP_OK      = 8'hA5;
    localparam logic [7:0] RSP_PONG    = 8'h5A;
    localparam logic [7:0] RSP_BADOP   = 8'hEE;
    localparam logic [7:0] RSP_TIMEOUT = 8'hEF;

    localparam int unsigned RESP_MAX = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARGS,
        ST_REQ,
        ST_BUS,
        ST_RESP
    } state_e;

    // Index of the final argument byte for a WRITE (9 bytes) or READ (4 bytes).
    function automatic logic [3:0] last_arg_idx(input logic is_write);
        return is_write ? 4'd8 : 4'd3;
    endfunction

endpackage

// File: rtl/bridge_resp_ser.sv
// Response serializer: loads up to RESP_MAX bytes (byte 0 sent first) and a length,
// then offers them one at a time on a valid/ready byte stream.
module bridge_resp_ser
    import uart_bus_bridge_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [8*RESP_MAX-1:0]   load_bytes,
    input  logic [2:0]              load_len,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    done
);

    logic [8*RESP_MAX-1:0] buf_q, buf_d;
    logic [2:0]            left_q, left_d;
    logic                  valid_q, valid_d;

    always_comb begin
        buf_d   = buf_q;
        left_d  = left_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            buf_d   = load_bytes;
            left_d  = load_len;
            valid_d = (load_len != 3'd0);
        end else if (valid_q && tx_ready) begin
            buf_d  = {8'h00, buf_q[8*RESP_MAX-1:8]};
            left_d = left_q - 3'd1;
            if (left_q == 3'd1) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = buf_q[7:0];

endmodule

// File: rtl/uart_bus_bridge.sv
// UART byte-command to native memory bus initiator: decodes PING/READ/WRITE,
// arbitrates for the bus, runs one transaction and returns a byte response.
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT  = 1024,
    parameter int unsigned BYTE_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        rx_overrun
);

    localparam int unsigned BUS_CW = $clog2(BUS_TIMEOUT + 1);
    localparam int unsigned GAP_CW = $clog2(BYTE_TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [3:0]          arg_cnt_q, arg_cnt_d;
    logic                is_write_q, is_write_d;
    logic [29:0]         addr_q, addr_d;      // word address, addr[31:2]
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          strb_q, strb_d;
    logic [GAP_CW-1:0]   gap_q, gap_d;
    logic [BUS_CW-1:0]   bus_cnt_q, bus_cnt_d;
    logic                bus_req_q, bus_req_d;
    logic                mem_valid_q, mem_valid_d;
    logic                overrun_q, overrun_d;

    logic                    ser_load;
    logic [8*RESP_MAX-1:0]   ser_bytes;
    logic [2:0]              ser_len;
    logic                    ser_done;

    always_comb begin
        state_d     = state_q;
        arg_cnt_d   = arg_cnt_q;
        is_write_d  = is_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        gap_d       = gap_q;
        bus_cnt_d   = bus_cnt_q;
        bus_req_d   = bus_req_q;
        mem_valid_d = mem_valid_q;
        overrun_d   = overrun_q;
        ser_load    = 1'b0;
        ser_bytes   = '0;
        ser_len     = '0;

        if (rx_valid && (state_q == ST_REQ || state_q == ST_BUS || state_q == ST_RESP)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        OP_PING: begin
                            ser_load  = 1'b1;
                            ser_bytes = {32'h0, RSP_PONG};
                            ser_len   = 3'd1;
                            state_d   = ST_RESP;
                        end
                        OP_WRITE, OP_READ: begin
                            is_write_d = (rx_data == OP_WRITE);
                            arg_cnt_d  = '0;
                            gap_d      = '0;
                            strb_d     = '0;
                            wdata_d    = '0;
                            state_d    = ST_ARGS;
                        end
                        default: begin
                            ser_load  = 1'b1;
                            ser_bytes = {32'h0, RSP_BADOP};
                            ser_len   = 3'd1;
                            state_d   = ST_RESP;
                        end
                    endcase
                end
            end

            ST_ARGS: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (rx_valid) begin
                    gap_d = '0;
                    case (arg_cnt_q)
                        4'd0:    addr_d[5:0]    = rx_data[7:2];
                        4'd1:    addr_d[13:6]   = rx_data;
                        4'd2:    addr_d[21:14]  = rx_data;
                        4'd3:    addr_d[29:22]  = rx_data;
                        4'd4:    wdata_d[7:0]   = rx_data;
                        4'd5:    wdata_d[15:8]  = rx_data;
                        4'd6:    wdata_d[23:16] = rx_data;
                        4'd7:    wdata_d[31:24] = rx_data;
                        default: strb_d         = rx_data[3:0];
                    endcase
                    arg_cnt_d = arg_cnt_q + 4'd1;
                    if (arg_cnt_q == last_arg_idx(is_write_q)) begin
                        bus_req_d = 1'b1;
                        state_d   = ST_REQ;
                    end
                end else if (gap_q == GAP_CW'(BYTE_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            ST_REQ: begin
                if (bus_gnt) begin
                    mem_valid_d = 1'b1;
                    bus_cnt_d   = '0;
                    state_d     = ST_BUS;
                end
            end

            ST_BUS: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    bus_req_d   = 1'b0;
                    ser_load    = 1'b1;
                    state_d     = ST_RESP;
                    if (is_write_q) begin
                        ser_bytes = {32'h0, RSP_OK};
                        ser_len   = 3'd1;
                    end else begin
                        ser_bytes = {mem_rdata, RSP_OK};
                        ser_len   = 3'd5;
                    end
                end else if (bus_cnt_q == BUS_CW'(BUS_TIMEOUT - 1)) begin
                    mem_valid_d = 1'b0;
                    bus_req_d   = 1'b0;
                    ser_load    = 1'b1;
                    ser_bytes   = {32'h0, RSP_TIMEOUT};
                    ser_len     = 3'd1;
                    state_d     = ST_RESP;
                end else begin
                    bus_cnt_d = bus_cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                if (ser_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            arg_cnt_q   <= '0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            gap_q       <= '0;
            bus_cnt_q   <= '0;
            bus_req_q   <= 1'b0;
            mem_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arg_cnt_q   <= arg_cnt_d;
            is_write_q  <= is_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            gap_q       <= gap_d;
            bus_cnt_q   <= bus_cnt_d;
            bus_req_q   <= bus_req_d;
            mem_valid_q <= mem_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    bridge_resp_ser u_ser (
        .clk        (clk),
        .rst        (rst),
        .load       (ser_load),
        .load_bytes (ser_bytes),
        .load_len   (ser_len),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .done       (ser_done)
    );

    // A write with an all-zero strobe goes out as a read.
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_valid_q ? {addr_q, 2'b00} : '0;
    assign mem_wstrb  = (mem_valid_q && is_write_q) ? strb_q : '0;
    assign mem_wdata  = (mem_valid_q && is_write_q && strb_q != 4'h0) ? wdata_q : '0;
    assign bus_req    = bus_req_q;
    assign busy       = (state_q != ST_IDLE);
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: commands push expected bus transactions and
// response bytes into queues; independent responder and tx monitors pop and compare.
module tb_uart_bus_bridge;

    localparam int unsigned BUS_T  = 16;
    localparam int unsigned BYTE_T = 100;

    typedef enum int {K_READY, K_TIMEOUT, K_ABORT} kind_e;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int unsigned delay;
        kind_e       kind;
    } bus_exp_t;

    logic        clk, rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        bus_req, bus_gnt;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy, rx_overrun;

    bus_exp_t    exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          errors = 0;
    int          checks = 0;
    bit          ready_random = 0;
    bit          resp_busy = 0;

    uart_bus_bridge #(.BUS_TIMEOUT(BUS_T), .BYTE_TIMEOUT(BYTE_T)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .rx_overrun(rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transmitter side ----------------
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %h expected no byte", tx_data);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", tx_data, e);
                end
            end
        end
    end

    // ---------------- arbiter ----------------
    initial begin
        int unsigned wait_n;
        bit just;
        bus_gnt = 1'b0;
        wait_n  = 0;
        just    = 0;
        forever begin
            @(posedge clk); #1;
            if (just && !rst) check("gnt_to_valid", mem_valid, 1);
            just = 0;
            if (!bus_req) begin
                bus_gnt = 1'b0;
                wait_n  = $urandom_range(0, 4);
            end else if (!bus_gnt) begin
                if (wait_n == 0) begin
                    bus_gnt = 1'b1;
                    just    = 1;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        bus_exp_t e;
        int unsigned n;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                resp_busy = 1;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got mem_addr %h expected no transaction", mem_addr);
                    n = 0;
                    while (mem_valid && n < 200) begin @(negedge clk); n++; end
                end else begin
                    e = exp_bus.pop_front();
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
                    if (e.wstrb != 4'h0) check("mem_wdata", mem_wdata, e.wdata);
                    case (e.kind)
                        K_READY: begin
                            repeat (e.delay) begin
                                @(negedge clk);
                                check("hold_valid", mem_valid, 1);
                                check("hold_addr", mem_addr, e.addr);
                                check("hold_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
                            end
                            @(posedge clk); #1;
                            mem_ready = 1'b1;
                            mem_rdata = e.rdata;
                            @(posedge clk); #1;
                            mem_ready = 1'b0;
                            mem_rdata = $urandom;
                            check("valid_drop", mem_valid, 0);
                            check("req_drop", bus_req, 0);
                            check("resp_latency", tx_valid, 1);
                        end
                        K_TIMEOUT: begin
                            n = 1;
                            while (n < 4 * BUS_T) begin
                                @(negedge clk);
                                if (!mem_valid) break;
                                n++;
                            end
                            check("timeout_len", n, BUS_T);
                            check("timeout_req", bus_req, 0);
                        end
                        default: begin
                            n = 0;
                            while (mem_valid && n < 200) begin @(negedge clk); n++; end
                        end
                    endcase
                end
                resp_busy = 0;
            end
        end
    end

    // ---------------- stimulus and reference model ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    endtask

    task automatic push_resp(input kind_e kind, input bit with_data, input logic [31:0] rdata);
        if (kind == K_TIMEOUT) exp_tx.push_back(8'hEF);
        else if (kind == K_READY) begin
            exp_tx.push_back(8'hA5);
            if (with_data) for (int i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int unsigned delay, input kind_e kind);
        bus_exp_t e;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.wdata = data;
        e.wstrb = strb[3:0];
        e.rdata = $urandom;
        e.delay = delay;
        e.kind  = kind;
        exp_bus.push_back(e);
        push_resp(kind, 0, 0);
        send_byte(8'h01);
        send_word(addr);
        send_word(data);
        send_byte(strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata,
                           input int unsigned delay, input kind_e kind);
        bus_exp_t e;
        e.addr  = addr & 32'hFFFF_FFFC;
        e.wdata = '0;
        e.wstrb = 4'h0;
        e.rdata = rdata;
        e.delay = delay;
        e.kind  = kind;
        exp_bus.push_back(e);
        push_resp(kind, 1, rdata);
        send_byte(8'h02);
        send_word(addr);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || resp_busy || exp_tx.size() != 0 || exp_bus.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done"}, n < 3000, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_txq"}, exp_tx.size(), 0);
        check({name, "_busq"}, exp_bus.size(), 0);
    endtask

    task automatic wait_mem_valid(input string name);
        int n = 0;
        while (!mem_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_mem_valid"}, mem_valid, 1);
    endtask

    initial begin
        logic [7:0] op;
        int unsigned k;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wstrb", {28'h0, mem_wstrb}, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", rx_overrun, 0);
        rst = 1'b0;

        // PING with one-cycle response latency
        exp_tx.push_back(8'h5A);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("ping_latency", tx_valid, 1);
        check("ping_no_req", bus_req, 0);
        wait_idle("ping");

        do_write(32'h1200_0000, 32'h0000_00A5, 8'h0F, 1, K_READY);
        wait_idle("write");

        ready_random = 1;
        do_read(32'h8000_0004, 32'hDEAD_BEEF, 2, K_READY);
        wait_idle("read");

        do_read(32'h0000_1000, 32'h0, 0, K_TIMEOUT);
        wait_idle("bus_timeout");

        exp_tx.push_back(8'hEE);
        send_byte(8'h7F);
        wait_idle("badop");

        // Partial WRITE abandoned after exactly BYTE_T idle cycles
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (BYTE_T - 1) @(posedge clk);
        #1;
        check("gap_still_busy", busy, 1);
        @(posedge clk); #1;
        check("gap_expired_idle", busy, 0);
        repeat (5) @(posedge clk);
        check("gap_no_req", bus_req, 0);
        exp_tx.push_back(8'h5A);
        send_byte(8'h03);
        wait_idle("ping_after_gap");

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            case (k)
                0, 1: do_write($urandom, $urandom, 8'($urandom), $urandom_range(0, 5), K_READY);
                2:    do_write($urandom, $urandom, {4'($urandom), 4'h0}, $urandom_range(0, 5), K_READY);
                3, 4, 5: do_read($urandom, $urandom, $urandom_range(0, 5), K_READY);
                6: begin
                    exp_tx.push_back(8'h5A);
                    send_byte(8'h03);
                end
                7: begin
                    op = 8'($urandom);
                    if (op >= 8'h01 && op <= 8'h03) op = 8'hC3;
                    exp_tx.push_back(8'hEE);
                    send_byte(op);
                end
                default: do_write($urandom, $urandom, 8'hFF, 0, K_TIMEOUT);
            endcase
            wait_idle("random");
        end

        // Byte received during BUS is dropped and flagged
        check("overrun_before", rx_overrun, 0);
        do_read(32'h4000_0010, 32'h1234_5678, 10, K_READY);
        wait_mem_valid("overrun");
        send_byte(8'h03);
        check("overrun_set", rx_overrun, 1);
        wait_idle("overrun");
        check("overrun_sticky", rx_overrun, 1);

        // Reset in the middle of a bus transaction
        do_read(32'h2000_0008, 32'h0, 0, K_ABORT);
        wait_mem_valid("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_mem_valid", mem_valid, 0);
        check("reset_bus_req", bus_req, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_overrun", rx_overrun, 0);
        repeat (10) @(posedge clk);
        wait_idle("reset");

        exp_tx.push_back(8'h5A);
        send_byte(8'h03);
        wait_idle("ping_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1);
    end

endmodule
